// File: rtl/ifetch_pkg.sv
// Core-wide defines shared by ifetch, ctrl and the IF/ID register:
// bubble instruction, hold levels and the default boot address.
package ifetch_pkg;

    localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0001;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        HOLD_NONE = 2'b00,
        HOLD_PC   = 2'b01,
        HOLD_IF   = 2'b10,
        HOLD_ID   = 2'b11
    } hold_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: small circular FIFO with flush; pop and push on a full
// FIFO in the same cycle is legal and keeps the count.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        rd_en    = pop_i && (count_q != '0);
        wr_en    = push_i && (!full || rd_en);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_en) rd_ptr_d = next_ptr(rd_ptr_q);
            if (wr_en && !rd_en) count_d = count_q + CNT_W'(1);
            else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: pipelined bus requests with a bounded number in flight,
// a prefetch buffer feeding IF/ID, and redirect with stale-response dropping.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  hold_flag_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] inst_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_addr_q, rsp_addr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W:0]   in_flight;
    logic             fire;
    logic             rsp_ok;
    logic             discard;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [63:0]      fifo_rdata;

    always_comb begin
        in_flight  = {1'b0, outstanding_q} + {1'b0, fifo_count};
        // Gated by rstn so the request is low while reset is held and rises
        // in the very first cycle after release.
        ibus_req_o = rstn && (hold_flag_i == HOLD_NONE) && !jump_flag_i
                     && (in_flight < (CNT_W + 1)'(DEPTH));
        fire       = ibus_req_o && ibus_gnt_i;
        rsp_ok     = ibus_rvalid_i && (outstanding_q != '0);
        discard    = rsp_ok && (drop_q != '0);
        push       = rsp_ok && !discard && !jump_flag_i;
        pop        = !fifo_empty && (hold_flag_i != HOLD_IF)
                     && (hold_flag_i != HOLD_ID) && !jump_flag_i;

        outstanding_d = outstanding_q;
        if (fire && !rsp_ok) outstanding_d = outstanding_q + CNT_W'(1);
        else if (!fire && rsp_ok) outstanding_d = outstanding_q - CNT_W'(1);

        // Everything still outstanding belongs to the old stream; any drop
        // already pending is a subset of it, so loading (not adding) avoids
        // counting those twice.
        drop_d = drop_q;
        if (jump_flag_i) drop_d = outstanding_q - CNT_W'(rsp_ok);
        else if (discard) drop_d = drop_q - CNT_W'(1);

        fetch_pc_d = fetch_pc_q;
        rsp_addr_d = rsp_addr_q;
        if (jump_flag_i) begin
            fetch_pc_d = word_align(jump_addr_i);
            rsp_addr_d = word_align(jump_addr_i);
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push) rsp_addr_d = rsp_addr_q + 32'd4;
        end

        if (!fifo_empty && !jump_flag_i) begin
            inst_addr_o = fifo_rdata[63:32];
            inst_o      = fifo_rdata[31:0];
        end else begin
            inst_addr_o = 32'h0;
            inst_o      = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc_q    <= RESET_ADDR;
            rsp_addr_q    <= RESET_ADDR;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_addr_q    <= rsp_addr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    assign ibus_addr_o = fetch_pc_q;

    ifetch_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdata_i ({rsp_addr_q, ibus_rdata_i}),
        .pop_i   (pop),
        .flush_i (jump_flag_i),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: in-order bus model plus a scoreboard of granted fetches
// compared against what leaves the prefetch buffer.
module tb_ifetch;

    localparam logic [31:0] NOP   = 32'h0000_0001;
    localparam logic [31:0] RADDR = 32'h0000_0000;

    logic        clk;
    logic        rstn;
    logic [1:0]  hold_flag_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_o;

    ifetch #(
        .RESET_ADDR (RADDR),
        .DEPTH      (2),
        .NOP_INST   (NOP)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .hold_flag_i   (hold_flag_i),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_addr_o   (inst_addr_o),
        .inst_o        (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int outputs_seen = 0;

    logic [31:0] bus_q [$];
    logic [63:0] exp_q [$];
    logic [31:0] exp_pc;
    bit          gnt_en;
    bit          rsp_en;
    bit          spur;
    logic        s_req;
    logic [31:0] s_addr, s_inst, s_iaddr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic monitor();
        logic [63:0] e;
        s_req   = ibus_req_o;
        s_addr  = ibus_addr_o;
        s_inst  = inst_o;
        s_iaddr = inst_addr_o;
        if (!rstn) return;
        if (jump_flag_i) begin
            check("jump_nop_inst", inst_o, NOP);
            check("jump_req_low", {31'h0, ibus_req_o}, 32'h0);
        end
        if (!jump_flag_i && hold_flag_i < 2'b10 && inst_o !== NOP) begin
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_addr", inst_addr_o, e[63:32]);
                check("out_inst", inst_o, e[31:0]);
                outputs_seen++;
            end
        end
        if (ibus_req_o && ibus_gnt_i) begin
            check("req_addr", ibus_addr_o, exp_pc);
            bus_q.push_back(ibus_addr_o);
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        if (jump_flag_i) begin
            exp_q.delete();
            exp_pc = {jump_addr_i[31:2], 2'b00};
        end
    endtask

    task automatic drive_bus();
        logic [31:0] a;
        ibus_gnt_i = gnt_en;
        if (spur) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_word(32'h40);
            spur = 1'b0;
        end else if (rsp_en && bus_q.size() != 0) begin
            a = bus_q.pop_front();
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_word(a);
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = 32'h0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rstn) drive_bus();
        else begin
            ibus_gnt_i    = 1'b0;
            ibus_rvalid_i = 1'b0;
        end
    endtask

    task automatic set_gnt(input bit b);
        gnt_en     = b;
        ibus_gnt_i = b;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] head, addr0;
        bit found;
        rstn = 1'b0; hold_flag_i = 2'b00; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
        gnt_en = 1'b1; rsp_en = 1'b1; spur = 1'b0; exp_pc = RADDR;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", {31'h0, ibus_req_o}, 32'h0);
        check("rst_inst", inst_o, NOP);
        check("rst_inst_addr", inst_addr_o, 32'h0);
        check("rst_fetch_addr", ibus_addr_o, RADDR);

        // Straight-line fetch with gnt tied high
        rstn = 1'b1;
        set_gnt(1'b1);
        cycle();
        check("first_req", {31'h0, s_req}, 32'h1);
        check("first_addr", s_addr, 32'h0);
        cycle();
        check("second_addr", s_addr, 32'h4);
        cycle();
        check("first_out_latency", s_iaddr, 32'h0);
        cycle();
        check("second_out", s_iaddr, 32'h4);
        repeat (10) cycle();

        // Fill the buffer, then hold IF
        rsp_en = 1'b0;
        repeat (4) cycle();
        hold_flag_i = 2'b10;
        rsp_en = 1'b1;
        repeat (3) cycle();
        head = inst_addr_o;
        check("hold_head_valid", {31'h0, inst_o !== NOP}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("hold_if_req_low", {31'h0, s_req}, 32'h0);
            check("hold_if_head", s_iaddr, head);
        end
        hold_flag_i = 2'b00;
        repeat (8) cycle();

        // gnt low for 5 cycles
        set_gnt(1'b0);
        addr0 = ibus_addr_o;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("gnt_low_addr_stable", s_addr, addr0);
        end
        check("gnt_low_drained_nop", s_inst, NOP);
        check("gnt_low_req_pending", {31'h0, s_req}, 32'h1);

        // rvalid with nothing outstanding
        spur = 1'b1;
        cycle();
        cycle();
        check("spurious_ignored_a", s_inst, NOP);
        cycle();
        check("spurious_ignored_b", s_inst, NOP);

        // Jump with two requests outstanding
        rsp_en = 1'b0;
        set_gnt(1'b1);
        repeat (3) cycle();
        jump_addr_i = 32'h0000_0103;
        jump_flag_i = 1'b1;
        rsp_en = 1'b1;
        cycle();
        jump_flag_i = 1'b0;
        cycle();
        check("jump_target_addr", s_addr, 32'h100);
        check("jump_full_req_low", {31'h0, s_req}, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (s_inst !== NOP) found = 1'b1;
        end
        check("jump_first_out_seen", {31'h0, found}, 32'h1);
        check("jump_first_out_addr", s_iaddr, 32'h100);
        repeat (6) cycle();

        // Jump together with hold ID
        hold_flag_i = 2'b11;
        jump_addr_i = 32'h0000_0200;
        jump_flag_i = 1'b1;
        cycle();
        hold_flag_i = 2'b00;
        jump_flag_i = 1'b0;
        cycle();
        check("jump_hold_id_addr", s_addr, 32'h200);
        repeat (10) cycle();

        // Address wrap
        jump_addr_i = 32'hFFFF_FFF8;
        jump_flag_i = 1'b1;
        cycle();
        jump_flag_i = 1'b0;
        repeat (14) cycle();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            gnt_en      = ($urandom_range(0, 3) != 0);
            rsp_en      = ($urandom_range(0, 3) != 0);
            hold_flag_i = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(0, 3));
            jump_flag_i = ($urandom_range(0, 19) == 0);
            jump_addr_i = $urandom();
            cycle();
        end
        jump_flag_i = 1'b0;
        hold_flag_i = 2'b00;
        rsp_en = 1'b1;
        set_gnt(1'b1);
        repeat (6) cycle();

        // Reset mid-burst
        rstn = 1'b0;
        #1;
        check("midrst_req", {31'h0, ibus_req_o}, 32'h0);
        check("midrst_inst", inst_o, NOP);
        check("midrst_inst_addr", inst_addr_o, 32'h0);
        check("midrst_fetch_addr", ibus_addr_o, RADDR);
        bus_q.delete();
        exp_q.delete();
        exp_pc = RADDR;
        ibus_rvalid_i = 1'b0;
        ibus_gnt_i = 1'b0;
        repeat (2) cycle();
        rstn = 1'b1;
        set_gnt(1'b1);
        cycle();
        check("restart_req", {31'h0, s_req}, 32'h1);
        check("restart_addr", s_addr, RADDR);
        repeat (10) cycle();

        // Drain and confirm every granted fetch was delivered
        set_gnt(1'b0);
        repeat (8) cycle();
        check("sb_drained", 32'(exp_q.size()), 32'h0);
        check("outputs_flowed", {31'h0, outputs_seen > 20}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
